// File: rtl/pc_gen.sv
// Fetch-PC generator: F-stage PC register, D-stage redirect decode, exception entry
// with stall-safe interrupt latching. Define PC_ALIGN_CHK_EN to build the fetch-address check.
module pc_gen #(
  parameter int unsigned     AW       = 32,
  parameter logic [AW-1:0]   RESET_PC = AW'(32'h0000_3000),
  parameter logic [AW-1:0]   EXC_VEC  = AW'(32'h0000_4180),
  parameter logic [AW-1:0]   IM_BASE  = AW'(32'h0000_3000),
  parameter logic [AW-1:0]   IM_BYTES = AW'(32'h0000_1000)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          stall,
  input  logic [2:0]    br_type,
  input  logic          cmp_zero,
  input  logic          cmp_more,
  input  logic          cmp_less,
  input  logic          is_j,
  input  logic          is_jr,
  input  logic          eret,
  input  logic [AW-1:0] pc4_d,
  input  logic [25:0]   i26_d,
  input  logic [AW-1:0] rs_d,
  input  logic [AW-1:0] epc,
  input  logic          irq,
  output logic [AW-1:0] pc_f,
  output logic [AW-1:0] pc4_f,
  output logic          bd_f,
  output logic          exc_taken,
  output logic          adel_f
);

  localparam logic [2:0] BR_NONE = 3'd0;
  localparam logic [2:0] BR_BEQ  = 3'd1;
  localparam logic [2:0] BR_BNE  = 3'd2;
  localparam logic [2:0] BR_BGTZ = 3'd3;
  localparam logic [2:0] BR_BLEZ = 3'd4;
  localparam logic [2:0] BR_BGEZ = 3'd5;
  localparam logic [2:0] BR_BLTZ = 3'd6;

  logic                 irq_pend;
  logic                 exc_req;
  logic                 br_taken;
  logic signed [AW-1:0] br_off;
  logic [AW-1:0]        br_tgt;
  logic [AW-1:0]        j_tgt;
  logic [AW-1:0]        pc_next;
  logic                 bd_next;

  always_comb begin
    br_taken = 1'b0;
    case (br_type)
      BR_BEQ:  br_taken = cmp_zero;
      BR_BNE:  br_taken = ~cmp_zero;
      BR_BGTZ: br_taken = cmp_more;
      BR_BLEZ: br_taken = ~cmp_more;
      BR_BGEZ: br_taken = ~cmp_less;
      BR_BLTZ: br_taken = cmp_less;
      default: br_taken = 1'b0;
    endcase
  end

  assign br_off = $signed({{(AW-18){i26_d[15]}}, i26_d[15:0], 2'b00});
  assign br_tgt = pc4_d + $unsigned(br_off);
  assign j_tgt  = {pc4_d[AW-1:28], i26_d, 2'b00};
  assign pc4_f  = pc_f + AW'(4);

  // A pending interrupt latched during a stall outranks everything once the stall lifts
  assign exc_req = irq | irq_pend;

  always_comb begin
    pc_next = pc4_f;
    if (exc_req)       pc_next = EXC_VEC;
    else if (eret)     pc_next = epc;
    else if (br_taken) pc_next = br_tgt;
    else if (is_j)     pc_next = j_tgt;
    else if (is_jr)    pc_next = rs_d;
  end

  // Untaken branches still own a delay slot; exception entry and eret do not
  assign bd_next = ((br_type != BR_NONE) | is_j | is_jr) & ~exc_req & ~eret;

  // ---- F-stage register boundary ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_f      <= RESET_PC;
      bd_f      <= 1'b0;
      exc_taken <= 1'b0;
      irq_pend  <= 1'b0;
    end else if (stall) begin
      exc_taken <= 1'b0;
      irq_pend  <= irq_pend | irq;
    end else begin
      pc_f      <= pc_next;
      bd_f      <= bd_next;
      exc_taken <= exc_req;
      irq_pend  <= 1'b0;
    end
  end

`ifdef PC_ALIGN_CHK_EN
  function automatic logic pc_bad(input logic [AW-1:0] pc);
    logic [AW:0] lo;
    logic [AW:0] hi;
    lo = {1'b0, IM_BASE};
    hi = {1'b0, IM_BASE} + {1'b0, IM_BYTES};
    return (pc[1:0] != 2'b00) || ({1'b0, pc} < lo) || ({1'b0, pc} >= hi);
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      adel_f <= 1'b0;
    else if (!stall) adel_f <= pc_bad(pc_next);
  end
`else
  assign adel_f = 1'b0;
`endif

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed cases plus randomized traffic against a
// behavioural reference model.
module tb_pc_gen;

  localparam logic [31:0] RST_PC = 32'h0000_3000;
  localparam logic [31:0] EXC_PC = 32'h0000_4180;
  localparam logic [31:0] IM_LO  = 32'h0000_3000;
  localparam logic [31:0] IM_SZ  = 32'h0000_1000;

  logic        clk;
  logic        reset;
  logic        stall;
  logic [2:0]  br_type;
  logic        cmp_zero, cmp_more, cmp_less;
  logic        is_j, is_jr, eret, irq;
  logic [31:0] pc4_d, rs_d, epc;
  logic [25:0] i26_d;
  logic [31:0] pc_f, pc4_f;
  logic        bd_f, exc_taken, adel_f;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  logic [31:0] m_pc;
  logic        m_bd, m_exc, m_pend, m_adel;

  pc_gen dut (
    .clk(clk), .reset(reset), .stall(stall), .br_type(br_type),
    .cmp_zero(cmp_zero), .cmp_more(cmp_more), .cmp_less(cmp_less),
    .is_j(is_j), .is_jr(is_jr), .eret(eret), .pc4_d(pc4_d), .i26_d(i26_d),
    .rs_d(rs_d), .epc(epc), .irq(irq), .pc_f(pc_f), .pc4_f(pc4_f),
    .bd_f(bd_f), .exc_taken(exc_taken), .adel_f(adel_f)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clear_in();
    stall = 0; br_type = 0; cmp_zero = 0; cmp_more = 0; cmp_less = 0;
    is_j = 0; is_jr = 0; eret = 0; irq = 0;
    pc4_d = 0; i26_d = 0; rs_d = 0; epc = 0;
  endtask

  task automatic model_reset();
    m_pc = RST_PC; m_bd = 0; m_exc = 0; m_pend = 0; m_adel = 0;
  endtask

  function automatic logic addr_bad(input logic [31:0] a);
    longint unsigned la;
    la = longint'(a);
    return (a[1:0] != 2'b00) || (la < longint'(IM_LO)) || (la >= longint'(IM_LO) + longint'(IM_SZ));
  endfunction

  task automatic compare_all(input string tag);
    check({tag, ".pc_f"}, pc_f, m_pc);
    check({tag, ".pc4_f"}, pc4_f, m_pc + 32'd4);
    check({tag, ".bd_f"}, 32'(bd_f), 32'(m_bd));
    check({tag, ".exc_taken"}, 32'(exc_taken), 32'(m_exc));
`ifdef PC_ALIGN_CHK_EN
    check({tag, ".adel_f"}, 32'(adel_f), 32'(m_adel));
`else
    check({tag, ".adel_f"}, 32'(adel_f), 32'd0);
`endif
  endtask

  // One clock: predict from current inputs, advance, then compare at the falling edge.
  task automatic tick(input string tag);
    logic [31:0] np;
    logic        exc, taken, nbd;
    int          off;
    exc = irq | m_pend;
    taken = (br_type == 1 && cmp_zero) || (br_type == 2 && !cmp_zero) ||
            (br_type == 3 && cmp_more) || (br_type == 4 && !cmp_more) ||
            (br_type == 5 && !cmp_less) || (br_type == 6 && cmp_less);
    off = int'($signed(i26_d[15:0]));
    if (exc)        np = EXC_PC;
    else if (eret)  np = epc;
    else if (taken) np = pc4_d + 32'(off * 4);
    else if (is_j)  np = {pc4_d[31:28], i26_d, 2'b00};
    else if (is_jr) np = rs_d;
    else            np = m_pc + 32'd4;
    nbd = (br_type != 0 || is_j || is_jr) && !exc && !eret;
    @(posedge clk);
    #1;
    if (!stall) begin
      m_pc = np; m_bd = nbd; m_exc = exc; m_pend = 0; m_adel = addr_bad(np);
    end else begin
      m_exc = 0; m_pend = m_pend | irq;
    end
    @(negedge clk);
    compare_all(tag);
  endtask

  initial begin
    clear_in();
    reset = 0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    compare_all("reset");
    check("reset_pc", pc_f, 32'h3000);
    reset = 1;

    tick("seq0"); check("seq0_pc", pc_f, 32'h3004);
    tick("seq1"); check("seq1_pc", pc_f, 32'h3008);
    tick("seq2"); check("seq2_pc", pc_f, 32'h300C); check("seq2_bd", 32'(bd_f), 0);

    br_type = 1; cmp_zero = 1; pc4_d = 32'h3008; i26_d = 26'h000FFFE;
    tick("beq_t"); check("beq_t_pc", pc_f, 32'h3000); check("beq_t_bd", 32'(bd_f), 1);
    cmp_zero = 0;
    tick("beq_nt"); check("beq_nt_pc", pc_f, 32'h3004); check("beq_nt_bd", 32'(bd_f), 1);
    clear_in();
    tick("plain"); check("plain_bd", 32'(bd_f), 0);

    is_j = 1; pc4_d = 32'h3010; i26_d = 26'h0000C40;
    tick("j"); check("j_pc", pc_f, 32'h3100);
    clear_in(); is_jr = 1; rs_d = 32'h3200;
    tick("jr"); check("jr_pc", pc_f, 32'h3200);
    clear_in();

    stall = 1;
    for (int i = 0; i < 4; i++) begin
      irq = (i == 1);
      tick("stall");
      check("stall_pc", pc_f, 32'h3200);
      check("stall_exc", 32'(exc_taken), 0);
    end
    stall = 0; irq = 0;
    tick("irq_entry"); check("irq_entry_pc", pc_f, EXC_PC);
    check("irq_entry_exc", 32'(exc_taken), 1); check("irq_entry_bd", 32'(bd_f), 0);
    tick("irq_after"); check("irq_after_exc", 32'(exc_taken), 0);
    check("irq_after_pc", pc_f, EXC_PC + 32'd4);

    irq = 1; eret = 1; epc = 32'h3040;
    tick("irq_eret"); check("irq_eret_pc", pc_f, EXC_PC);
    irq = 0;
    tick("eret"); check("eret_pc", pc_f, 32'h3040);
    clear_in();

    stall = 1; irq = 1; tick("dbl0"); irq = 0; tick("dbl1"); irq = 1; tick("dbl2");
    stall = 0; irq = 0;
    tick("dbl_entry"); check("dbl_entry_exc", 32'(exc_taken), 1);
    tick("dbl_once"); check("dbl_once_exc", 32'(exc_taken), 0);

    stall = 1; irq = 1; tick("rst_stall"); irq = 0;
    reset = 0; #1;
    model_reset();
    compare_all("rst_async"); check("rst_async_pc", pc_f, 32'h3000);
    @(negedge clk); reset = 1; stall = 0;
    tick("rst_rel"); check("rst_rel_pc", pc_f, 32'h3004); check("rst_rel_exc", 32'(exc_taken), 0);

    is_jr = 1; rs_d = 32'hFFFF_FFFC; tick("wrap_a");
    clear_in(); tick("wrap_b"); check("wrap_pc", pc_f, 32'h0);

`ifdef PC_ALIGN_CHK_EN
    is_jr = 1; rs_d = 32'h3002; tick("adel_a");
    check("adel_a_pc", pc_f, 32'h3002); check("adel_a", 32'(adel_f), 1);
    rs_d = 32'h5000; tick("adel_b"); check("adel_b", 32'(adel_f), 1);
    rs_d = 32'h3004; tick("adel_c"); check("adel_c", 32'(adel_f), 0);
    clear_in();
`endif

    for (int n = 0; n < 600; n++) begin
      if ($urandom % 150 == 0) begin
        reset = 0; #1;
        model_reset();
        compare_all("rnd_rst");
        #1 reset = 1;
      end
      stall    = ($urandom % 4 == 0);
      irq      = ($urandom % 12 == 0);
      br_type  = ($urandom % 3 == 0) ? 3'($urandom % 7) : 3'd0;
      cmp_zero = 1'($urandom); cmp_more = 1'($urandom); cmp_less = 1'($urandom);
      is_j     = ($urandom % 6 == 0);
      is_jr    = ($urandom % 6 == 0);
      eret     = ($urandom % 10 == 0);
      pc4_d    = ($urandom % 4 == 0) ? $urandom : m_pc + 32'd4;
      i26_d    = 26'($urandom);
      rs_d     = 32'h2FF0 + 32'($urandom % 32'h1020);
      epc      = 32'h3000 + {18'd0, 12'($urandom), 2'b00};
      tick("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Parametrised fetch-PC generator for the 5-stage MIPS pipeline.
- Owns the F-stage PC register and decodes D-stage branch/jump/jr/eret redirects.
- Handles exception-vector entry and latches interrupts that arrive during a stall so they are never lost.
- Produces a registered branch-delay-slot flag that the CP0 EPC logic consumes.

Parameters:
- AW, 32, PC width in bits; must be >= 29.
- RESET_PC, 32'h0000_3000, PC value loaded at reset.
- EXC_VEC, 32'h0000_4180, exception/interrupt entry address.
- IM_BASE, 32'h0000_3000, instruction-memory base address; used only by the optional check.
- IM_BYTES, 32'h0000_1000, instruction-memory size in bytes; used only by the optional check.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- stall  in  1  freeze F/D; PC holds.
- br_type  in  3  D-stage branch kind: 0 none, 1 beq, 2 bne, 3 bgtz, 4 blez, 5 bgez, 6 bltz.
- cmp_zero  in  1  D-stage rs==rt.
- cmp_more  in  1  D-stage rs>0 (signed).
- cmp_less  in  1  D-stage rs<0 (signed).
- is_j  in  1  D-stage j or jal.
- is_jr  in  1  D-stage jr or jalr.
- eret  in  1  D-stage eret.
- pc4_d  in  AW  D-stage PC+4.
- i26_d  in  26  D-stage instr[25:0].
- rs_d  in  AW  forwarded rs value.
- epc  in  AW  CP0 EPC.
- irq  in  1  exception/interrupt request; may be a one-cycle pulse.
- pc_f  out  AW  current fetch PC.
- pc4_f  out  AW  pc_f+4.
- bd_f  out  1  the instruction at pc_f is a delay slot.
- exc_taken  out  1  one-cycle pulse, registered; asserted the cycle pc_f==EXC_VEC after an entry.
- adel_f  out  1  fetch address error (optional feature).

Behaviour:
- Reset (asynchronous, active-low):
  - pc_f=RESET_PC, bd_f=0, exc_taken=0, adel_f=0, irq_pend=0.
- Target computation (combinational):
  - Branch taken when: beq&zero, bne&!zero, bgtz&more, blez&!more, bgez&!less, bltz&less.
  - br_tgt = pc4_d + (sext(i26_d[15:0])<<2), computed mod 2^AW.
  - j_tgt = {pc4_d[AW-1:28], i26_d, 2'b00}.
- Next-PC priority, highest first:
  - (irq|irq_pend) -> EXC_VEC
  - eret -> epc
  - branch taken -> br_tgt
  - is_j -> j_tgt
  - is_jr -> rs_d
  - otherwise -> pc_f+4
- Update when stall=0:
  - pc_f <= next PC.
  - bd_f <= (br_type!=0 | is_j | is_jr) & !(irq|irq_pend) & !eret.
  - An untaken branch still sets bd_f.
  - exc_taken <= (irq|irq_pend); irq_pend <= 0.
- Update when stall=1:
  - pc_f and bd_f hold; exc_taken <= 0.
  - irq_pend <= irq_pend | irq.
- irq/stall interaction:
  - irq arriving during a stall is applied on the first cycle with stall=0, including when irq has already dropped.
  - Two irqs during one stall produce a single entry.
  - irq while stall=0 redirects in the same cycle; irq_pend stays 0.
- Simultaneous requests resolve strictly by the priority list; e.g. irq+eret -> EXC_VEC.
- Latency: a redirect decided in D is visible on pc_f one cycle later. There is no extra bubble; the delay slot is the already-fetched instruction.
- Wrap-around: pc_f+4 at 2^AW-4 yields 0; no error unless the optional check is enabled.
- Reset asserted mid-stall or with irq_pend=1 clears everything; no deferred entry after reset release.

Optional Feature:
- PC_ALIGN_CHK_EN defined:
  - adel_f is registered alongside pc_f.
  - adel_f=1 when the loaded PC has [1:0]!=0 or lies outside [IM_BASE, IM_BASE+IM_BYTES).
  - pc_f still loads the offending value, so EPC logic sees it.
  - adel_f holds during stall.
- PC_ALIGN_CHK_EN not defined:
  - adel_f is tied to 0 and no comparison logic is built.

Test Plan:
- Reset release, stall=0, no redirects, 3 cycles -> pc_f 3000, 3004, 3008, 300C; bd_f=0 throughout.
- br_type=1, cmp_zero=1, pc4_d=3008, i26_d[15:0]=16'hFFFE -> next pc_f=3000, bd_f=1; the same with cmp_zero=0 -> pc_f=pc_f+4, bd_f=1.
- is_j=1, pc4_d=3010, i26_d=26'h0000C40 -> pc_f=3100; then is_jr=1, rs_d=3200 -> pc_f=3200.
- stall=1 for 4 cycles with a 1-cycle irq pulse in cycle 2, then stall=0:
  - pc_f unchanged during the stall.
  - Next edge pc_f=4180, exc_taken=1 for exactly 1 cycle, bd_f=0.
- irq=1 and eret=1 together with epc=3040 -> pc_f=4180. Then eret alone -> pc_f=3040.
- PC_ALIGN_CHK_EN: is_jr with rs_d=3002 -> pc_f=3002, adel_f=1. rs_d=5000 -> adel_f=1. rs_d=3004 -> adel_f=0.
